wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
// Writeback arbiter feeding the 3-port register file write port (we3/wa3/wd3).
// Merges single-cycle ALU/load results with results from a long-latency unit
// (mul/div) through a small FIFO, and keeps a pending-register scoreboard so
// decode can stall on RAW/WAW hazards against in-flight long-latency results.
// PARAMETERS
// XLEN   32  data width of write-back values
// DEPTH  2   long-latency result FIFO entries (>=1, power of 2)
// PORTS
// clk          in   1     rising-edge clock
// rst_n        in   1     asynchronous active-low reset
// alu_we       in   1     single-cycle result valid this cycle
// alu_wa       in   5     single-cycle destination register
// alu_wd       in   XLEN  single-cycle result data
// iss_valid    in   1     long-latency op issued this cycle
// iss_wa       in   5     destination of issued long-latency op
// lu_valid     in   1     long-latency result offered
// lu_ready     out  1     FIFO can accept result (= !full)
// lu_wa        in   5     long-latency result destination
// lu_wd        in   XLEN  long-latency result data
// ra1, ra2     in   5     decode source registers for hazard check
// hazard       out  1     source or alu_wa of decode hits a pending register
// we3          out  1     register-file write enable (registered)
// wa3          out  5     register-file write address (registered)
// wd3          out  XLEN  register-file write data (registered)
// BEHAVIOUR
// - Reset (async, rst_n=0): we3=0, wa3=0, wd3=0, FIFO empty, pending=0,
//   lu_ready=1 after release; hazard reflects pending=0 (i.e. 0).
// - Arbitration each cycle: alu_we=1 has absolute priority; else FIFO head
//   popped if non-empty; else idle. Winner latched into we3/wa3/wd3 on the
//   next rising edge -> 1-cycle latency from input to register-file write.
// - Writes to x0 never produce we3=1 (ALU: dropped; FIFO head: popped, dropped).
// - FIFO push when lu_valid && lu_ready. lu_ready = !full; no pass-through
//   when full, even if a pop occurs the same cycle. Push+pop same cycle when
//   not full: count unchanged, order preserved. Pointers wrap mod DEPTH.
// - Scoreboard pending[31:1]: set on iss_valid (iss_wa!=0); cleared when a
//   FIFO entry with that wa is popped. Same-cycle set and clear of one reg:
//   set wins. pending[0] is constant 0.
// - hazard = pending[ra1] | pending[ra2] | (alu_we & pending[alu_wa]);
//   combinational, x0 never hazards. Decode must stall while hazard=1.
// - ALU write to a pending register is illegal (decode stalls); bench asserts.
// - Reset mid-operation discards FIFO contents and pending bits immediately;
//   any we3 in flight drops to 0 asynchronously.
// STRUCTURE
// - Package wb_pkg: typedef struct packed {logic [4:0] wa; logic [XLEN-1:0] wd;}
//   wb_req_t; localparam NREG=32, AW=5.
// - Sub-module wb_fifo (DEPTH x wb_req_t, full/empty, async active-low reset).
// - Top: arbitration mux, output register, scoreboard vector, hazard logic.
// TESTING
// 1 Reset: rst_n=0 mid-stream with 2 FIFO entries -> we3=0, lu_ready=1,
//   hazard=0 next cycle after release, no stale writes appear.
// 2 ALU only: alu_we=1, wa=5, wd=0xDEADBEEF -> next cycle we3=1, wa3=5,
//   wd3=0xDEADBEEF; alu_wa=0 -> we3 stays 0.
// 3 Priority: FIFO holds {7,0x11}; alu_we=1 {3,0x22} three cycles -> writes
//   3,3,3 then 7 on 4th cycle; pending[7] clears when 7 popped.
// 4 Full: DEPTH=2, alu_we=1 held, push {8,1},{9,2} -> lu_ready=0 on 3rd offer;
//   drop alu_we -> 8 then 9 written in order, lu_ready=1 after first pop.
// 5 Hazard: iss_valid wa=12; ra1=12 -> hazard=1; ra2=0 alone -> 0; after
//   result {12,0x5} written -> hazard=0; iss and pop of 12 same cycle -> stays 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and sizes for the register-file writeback path.
package wb_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding long-latency results until the write port is free.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  // Explicit wrap keeps the pointers correct for any DEPTH, not only powers of 2.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the write port, queued long-latency results fill idle cycles.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_we,
  input  logic [4:0]      alu_wa,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            iss_valid,
  input  logic [4:0]      iss_wa,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_wa,
  input  logic [XLEN-1:0] lu_wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic            hazard,
  output logic            we3,
  output logic [4:0]      wa3,
  output logic [XLEN-1:0] wd3
);

  wb_req_t          lu_req;
  wb_req_t          head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             win_we;
  logic [4:0]       win_wa;
  logic [XLEN-1:0]  win_wd;
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_next;

  assign lu_req.wa = lu_wa;
  assign lu_req.wd = lu_wd;
  assign lu_ready  = ~full;
  assign push      = lu_valid & ~full;
  assign pop       = ~alu_we & ~empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (lu_req),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // A popped x0 head still leaves the FIFO; it just never raises we3.
  always_comb begin
    win_we = 1'b0;
    win_wa = '0;
    win_wd = '0;
    if (alu_we) begin
      win_we = (alu_wa != '0);
      win_wa = alu_wa;
      win_wd = alu_wd;
    end else if (!empty) begin
      win_we = (head.wa != '0);
      win_wa = head.wa;
      win_wd = head.wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= win_we;
      if (win_we) begin
        wa3 <= win_wa;
        wd3 <= win_wd;
      end
    end
  end

  // Set is applied after clear so a reissue of the same register keeps it pending.
  always_comb begin
    pending_next = pending;
    if (pop && head.wa != '0) pending_next[head.wa] = 1'b0;
    if (iss_valid && iss_wa != '0) pending_next[iss_wa] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

  assign hazard = pending[ra1] | pending[ra2] | (alu_we & pending[alu_wa]);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, reset/hazard sequences, random run vs. queue model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        alu_we;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        iss_valid;
  logic [4:0]  iss_wa;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        hazard;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;

  wb_arbiter #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_we    (alu_we),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .iss_valid (iss_valid),
    .iss_wa    (iss_wa),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_wa     (lu_wa),
    .lu_wd     (lu_wd),
    .ra1       (ra1),
    .ra2       (ra2),
    .hazard    (hazard),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_we;
    logic [4:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        iss_valid;
    logic [4:0]  iss_wa;
    logic        lu_valid;
    logic [4:0]  lu_wa;
    logic [31:0] lu_wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        e_ready;
    logic        e_hazard;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  int   total = 0;
  int   bad   = 0;
  ent_t mq[$];
  bit   pend [32];

  function automatic vec_t mk(logic aw, logic [4:0] awa, logic [31:0] awd,
                              logic iv, logic [4:0] iwa,
                              logic lv, logic [4:0] lwa, logic [31:0] lwd,
                              logic [4:0] r1, logic [4:0] r2,
                              logic er, logic eh, logic ew, logic [4:0] ewa, logic [31:0] ewd);
    vec_t v;
    v.alu_we = aw;  v.alu_wa = awa;  v.alu_wd = awd;
    v.iss_valid = iv; v.iss_wa = iwa;
    v.lu_valid = lv; v.lu_wa = lwa; v.lu_wd = lwd;
    v.ra1 = r1; v.ra2 = r2;
    v.e_ready = er; v.e_hazard = eh; v.e_we = ew; v.e_wa = ewa; v.e_wd = ewd;
    return v;
  endfunction

  function automatic vec_t idle(logic [4:0] r1, logic [4:0] r2);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 0, 0, 0, 0, 0);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    foreach (pend[i]) pend[i] = 0;
  endfunction

  // Drive one cycle of inputs, check combinational outputs, clock, check the write port.
  task automatic apply_stimulus(input vec_t v, input bit use_tbl);
    bit          m_ready, m_haz, m_we, popped;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    ent_t        h;
    alu_we = v.alu_we; alu_wa = v.alu_wa; alu_wd = v.alu_wd;
    iss_valid = v.iss_valid; iss_wa = v.iss_wa;
    lu_valid = v.lu_valid; lu_wa = v.lu_wa; lu_wd = v.lu_wd;
    ra1 = v.ra1; ra2 = v.ra2;
    #1;
    m_ready = (mq.size() < DEPTH);
    m_haz   = pend[v.ra1] | pend[v.ra2] | (v.alu_we & pend[v.alu_wa]);
    check_output("lu_ready", {31'd0, lu_ready}, {31'd0, m_ready});
    check_output("hazard", {31'd0, hazard}, {31'd0, m_haz});
    if (use_tbl) begin
      check_output("tbl_lu_ready", {31'd0, lu_ready}, {31'd0, v.e_ready});
      check_output("tbl_hazard", {31'd0, hazard}, {31'd0, v.e_hazard});
    end
    assert (!(v.alu_we && v.alu_wa != 0 && pend[v.alu_wa]))
      else $error("[TB] bench drove an ALU write to a pending register %0d", v.alu_wa);
    m_we = 0; m_wa = 0; m_wd = 0; popped = 0;
    if (v.alu_we) begin
      m_we = (v.alu_wa != 0); m_wa = v.alu_wa; m_wd = v.alu_wd;
    end else if (mq.size() > 0) begin
      h = mq.pop_front(); popped = 1;
      m_we = (h.wa != 0); m_wa = h.wa; m_wd = h.wd;
    end
    if (popped) pend[h.wa] = 0;
    if (v.iss_valid) pend[v.iss_wa] = 1;
    pend[0] = 0;
    if (v.lu_valid && m_ready) mq.push_back('{wa: v.lu_wa, wd: v.lu_wd});
    @(posedge clk);
    #1;
    check_output("we3", {31'd0, we3}, {31'd0, m_we});
    if (m_we) begin
      check_output("wa3", {27'd0, wa3}, {27'd0, m_wa});
      check_output("wd3", wd3, m_wd);
    end
    if (use_tbl) begin
      check_output("tbl_we3", {31'd0, we3}, {31'd0, v.e_we});
      if (v.e_we) begin
        check_output("tbl_wa3", {27'd0, wa3}, {27'd0, v.e_wa});
        check_output("tbl_wd3", wd3, v.e_wd);
      end
    end
  endtask

  vec_t tbl [26];

  initial begin
    vec_t v;
    bit   aw;
    logic [4:0] r;

    //            aw awa awd           iv iwa lv lwa lwd      r1  r2  rdy haz we wa  wd
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0,  0, 0,  0,       0,  0,  1, 0, 1, 5,  32'hDEADBEEF);
    tbl[1]  = mk(1, 0, 32'h00001234, 0, 0,  0, 0,  0,       0,  0,  1, 0, 0, 0,  0);
    tbl[2]  = mk(0, 0, 0,            1, 7,  0, 0,  0,       0,  0,  1, 0, 0, 0,  0);
    tbl[3]  = mk(1, 3, 32'h22,       0, 0,  1, 7,  32'h11,  7,  0,  1, 1, 1, 3,  32'h22);
    tbl[4]  = mk(1, 3, 32'h22,       0, 0,  0, 0,  0,       7,  0,  1, 1, 1, 3,  32'h22);
    tbl[5]  = mk(1, 3, 32'h22,       0, 0,  0, 0,  0,       0,  0,  1, 0, 1, 3,  32'h22);
    tbl[6]  = mk(0, 0, 0,            0, 0,  0, 0,  0,       7,  0,  1, 1, 1, 7,  32'h11);
    tbl[7]  = mk(0, 0, 0,            0, 0,  0, 0,  0,       7,  0,  1, 0, 0, 0,  0);
    tbl[8]  = mk(1, 1, 32'hA,        0, 0,  1, 8,  32'h1,   0,  0,  1, 0, 1, 1,  32'hA);
    tbl[9]  = mk(1, 1, 32'hB,        0, 0,  1, 9,  32'h2,   0,  0,  1, 0, 1, 1,  32'hB);
    tbl[10] = mk(1, 1, 32'hC,        0, 0,  1, 10, 32'h3,   0,  0,  0, 0, 1, 1,  32'hC);
    tbl[11] = mk(0, 0, 0,            0, 0,  1, 10, 32'h3,   0,  0,  0, 0, 1, 8,  32'h1);
    tbl[12] = mk(0, 0, 0,            0, 0,  0, 0,  0,       0,  0,  1, 0, 1, 9,  32'h2);
    tbl[13] = mk(0, 0, 0,            0, 0,  0, 0,  0,       0,  0,  1, 0, 0, 0,  0);
    tbl[14] = mk(0, 0, 0,            0, 0,  1, 0,  32'h55,  0,  0,  1, 0, 0, 0,  0);
    tbl[15] = mk(0, 0, 0,            0, 0,  0, 0,  0,       0,  0,  1, 0, 0, 0,  0);
    tbl[16] = mk(0, 0, 0,            0, 0,  0, 0,  0,       0,  0,  1, 0, 0, 0,  0);
    tbl[17] = mk(0, 0, 0,            1, 12, 0, 0,  0,       0,  0,  1, 0, 0, 0,  0);
    tbl[18] = mk(0, 0, 0,            0, 0,  0, 0,  0,       12, 0,  1, 1, 0, 0,  0);
    tbl[19] = mk(0, 0, 0,            0, 0,  0, 0,  0,       0,  12, 1, 1, 0, 0,  0);
    tbl[20] = mk(0, 0, 0,            0, 0,  1, 12, 32'h5,   12, 0,  1, 1, 0, 0,  0);
    tbl[21] = mk(0, 0, 0,            1, 12, 0, 0,  0,       12, 0,  1, 1, 1, 12, 32'h5);
    tbl[22] = mk(0, 0, 0,            0, 0,  0, 0,  0,       12, 0,  1, 1, 0, 0,  0);
    tbl[23] = mk(0, 0, 0,            0, 0,  1, 12, 32'h6,   12, 0,  1, 1, 0, 0,  0);
    tbl[24] = mk(0, 0, 0,            0, 0,  0, 0,  0,       12, 0,  1, 1, 1, 12, 32'h6);
    tbl[25] = mk(0, 0, 0,            0, 0,  0, 0,  0,       12, 0,  1, 0, 0, 0,  0);

    rst_n = 1'b0;
    alu_we = 0; alu_wa = 0; alu_wd = 0; iss_valid = 0; iss_wa = 0;
    lu_valid = 0; lu_wa = 0; lu_wd = 0; ra1 = 3; ra2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_output("rst_we3", {31'd0, we3}, 32'd0);
    check_output("rst_wa3", {27'd0, wa3}, 32'd0);
    check_output("rst_wd3", wd3, 32'd0);
    check_output("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    check_output("rst_hazard", {31'd0, hazard}, 32'd0);
    @(posedge clk);
    #1;

    // Mid-stream reset with two queued results and two pending registers.
    apply_stimulus(mk(1, 4, 32'h1, 1, 20, 1, 20, 32'hAA, 0, 0, 0, 0, 0, 0, 0), 0);
    apply_stimulus(mk(1, 4, 32'h2, 1, 21, 1, 21, 32'hBB, 0, 0, 0, 0, 0, 0, 0), 0);
    ra1 = 20; ra2 = 21;
    #2 rst_n = 1'b0;
    #1;
    check_output("async_we3", {31'd0, we3}, 32'd0);
    check_output("async_lu_ready", {31'd0, lu_ready}, 32'd1);
    check_output("async_hazard", {31'd0, hazard}, 32'd0);
    model_reset();
    alu_we = 0; iss_valid = 0; lu_valid = 0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) apply_stimulus(idle(20, 21), 0);

    for (int i = 0; i < 26; i++) apply_stimulus(tbl[i], 1);

    // The ALU-destination term of hazard, probed without letting the write commit.
    apply_stimulus(mk(0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    alu_we = 1; alu_wa = 15; ra1 = 0; ra2 = 0;
    #1;
    check_output("alu_wa_hazard", {31'd0, hazard}, 32'd1);
    alu_we = 0;
    #1;
    check_output("alu_wa_idle_hazard", {31'd0, hazard}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      r  = 5'($urandom_range(0, 7));
      aw = ($urandom_range(0, 99) < 40) && !pend[r];
      v = mk(aw, r, $urandom(),
             ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom(),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             0, 0, 0, 0, 0);
      apply_stimulus(v, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
